scan_select_seq: RTL and testbench

//  Upstream sequencer for the 2-to-4 one-hot decoder stage. Drives its select

---
 rtl/scan_select_seq.sv | 150 +++++++++++++++
 tb/tb_scan_select_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/scan_select_seq.sv
// Scan sequencer for a 2-to-4 one-hot decoder: steps {a,b} through channels with dwell and blanking.
// Optional build macro SCAN_MASK_EN adds a per-channel enable mask input.
module scan_select_seq #(
    parameter int DIV_W = 8,
    parameter int BLANK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             oneshot,
    input  logic [DIV_W-1:0] div,
`ifdef SCAN_MASK_EN
    input  logic [3:0]       mask,
`endif
    output logic             a,
    output logic             b,
    output logic             en,
    output logic             busy,
    output logic             done
);

    localparam int BCW = (BLANK > 1) ? $clog2(BLANK) : 1;
    localparam logic [BCW-1:0] BLANK_LAST = (BLANK > 0) ? BCW'(BLANK - 1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

    state_t           state, state_n;
    logic [1:0]       sel, sel_n;
    logic [BCW-1:0]   bcnt, bcnt_n;
    logic [DIV_W-1:0] dcnt, dcnt_n;
    logic             os_q, os_n;
    logic             done_n;
    logic             enter;
    logic [3:0]       mask_eff;
    logic [3:0]       above;

`ifdef SCAN_MASK_EN
    assign mask_eff = mask;
`else
    assign mask_eff = 4'hF;
`endif

    function automatic logic [1:0] lowest(input logic [3:0] m);
        lowest = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (m[i]) lowest = 2'(i);
    endfunction

    // Enabled channels strictly above the current one, for the next-channel search.
    always_comb begin
        above = '0;
        for (int i = 0; i < 4; i++)
            above[i] = mask_eff[i] && (i > int'(sel));
    end

    always_comb begin
        state_n = state;
        sel_n   = sel;
        bcnt_n  = bcnt;
        dcnt_n  = dcnt;
        os_n    = os_q;
        done_n  = 1'b0;
        enter   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !stop) begin
                    os_n = oneshot;
                    if (mask_eff == 4'b0) begin
                        done_n = oneshot;
                    end else begin
                        sel_n = lowest(mask_eff);
                        enter = 1'b1;
                    end
                end
            end
            S_BLANK: begin
                if (stop) begin
                    state_n = S_IDLE;
                    sel_n   = '0;
                end else if (bcnt == BLANK_LAST) begin
                    state_n = S_DRIVE;
                    dcnt_n  = div;
                end else begin
                    bcnt_n = bcnt + 1'b1;
                end
            end
            S_DRIVE: begin
                if (stop) begin
                    state_n = S_IDLE;
                    sel_n   = '0;
                end else if (dcnt == '0) begin
                    if (above != 4'b0) begin
                        sel_n = lowest(above);
                        enter = 1'b1;
                    end else if (mask_eff == 4'b0 || os_q) begin
                        state_n = S_IDLE;
                        sel_n   = '0;
                        done_n  = 1'b1;
                    end else begin
                        sel_n = lowest(mask_eff);
                        enter = 1'b1;
                    end
                end else begin
                    dcnt_n = dcnt - 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                sel_n   = '0;
            end
        endcase
        // Dwell is loaded on every DRIVE entry, so div changes mid-window are ignored.
        if (enter) begin
            if (BLANK == 0) begin
                state_n = S_DRIVE;
                dcnt_n  = div;
            end else begin
                state_n = S_BLANK;
                bcnt_n  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            sel   <= '0;
            bcnt  <= '0;
            dcnt  <= '0;
            os_q  <= 1'b0;
            en    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            sel   <= sel_n;
            bcnt  <= bcnt_n;
            dcnt  <= dcnt_n;
            os_q  <= os_n;
            en    <= (state_n == S_DRIVE);
            busy  <= (state_n != S_IDLE);
            done  <= done_n;
        end
    end

    assign a = sel[1];
    assign b = sel[0];

endmodule

// File: tb/tb_scan_select_seq.sv
// Directed scoreboard bench for scan_select_seq: per-cycle expected {a,b,en,busy,done} queued at stimulus.
module tb_scan_select_seq;

    localparam int BLANK = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop, oneshot;
    logic [7:0] div;
    logic [3:0] mask;
    logic       a, b, en, busy, done;
    logic       start0, stop0;
    logic       a0, b0, en0, busy0, done0;

    int total = 0;
    int bad   = 0;
    string tag = "init";

    logic [4:0] q[$];
    logic [4:0] q0[$];

    always #5 clk = ~clk;

    scan_select_seq #(.DIV_W(8), .BLANK(BLANK)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .oneshot(oneshot), .div(div),
`ifdef SCAN_MASK_EN
        .mask(mask),
`endif
        .a(a), .b(b), .en(en), .busy(busy), .done(done)
    );

    scan_select_seq #(.DIV_W(8), .BLANK(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .stop(stop0), .oneshot(oneshot), .div(div),
`ifdef SCAN_MASK_EN
        .mask(mask),
`endif
        .a(a0), .b(b0), .en(en0), .busy(busy0), .done(done0)
    );

    wire [4:0] obs  = {a, b, en, busy, done};
    wire [4:0] obs0 = {a0, b0, en0, busy0, done0};

    always @(negedge clk) begin : mon
        logic [4:0] e;
        if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s t=%0t got=%b want=%b", tag, $time, obs, e);
            end
        end
        if (q0.size() > 0) begin
            e = q0.pop_front();
            total++;
            assert (obs0 === e) else begin
                bad++;
                $error("FAIL %s_b0 t=%0t got=%b want=%b", tag, $time, obs0, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input logic e, input logic bz, input logic d);
        q.push_back({2'(ch), e, bz, d});
    endtask

    // One channel as seen by the decoder: BLANK cycles with en low, then dv+1 with en high.
    task automatic push_chan(input int ch, input int dv);
        repeat (BLANK) push(ch, 1'b0, 1'b1, 1'b0);
        repeat (dv + 1) push(ch, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic chk(input string t, input logic [4:0] got, input logic [4:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%b want=%b", t, got, want);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() > 0 || q0.size() > 0) && n < 500) begin
            tick();
            n++;
        end
        total++;
        assert (q.size() == 0 && q0.size() == 0) else begin
            bad++;
            $error("FAIL %s_timeout got=%0d want=0", tag, q.size() + q0.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 0; stop = 0; oneshot = 0; div = 0; mask = 4'hF;
        start0 = 0; stop0 = 0;
        #2;
        chk("reset", obs, 5'b0);
        chk("reset_b0", obs0, 5'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk("idle_after_reset", obs, 5'b0);

        // One-shot pass, BLANK=2, div=3: done at cycle 25.
        tick(); tag = "oneshot";
        start = 1; oneshot = 1; div = 3;
        push(0, 0, 0, 0);
        for (int ch = 0; ch < 4; ch++) push_chan(ch, 3);
        push(0, 0, 0, 1);
        push(0, 0, 0, 0);
        tick(); start = 0;
        drain();

        // Continuous, BLANK=0, div=0: one channel per cycle, en held.
        tick(); tag = "cont_b0";
        start0 = 1; oneshot = 0; div = 0;
        q0.push_back(5'b0);
        for (int i = 0; i < 10; i++) q0.push_back({2'(i % 4), 3'b110});
        tick(); start0 = 0;
        drain();
        stop0 = 1;
        tick(); stop0 = 0;
        chk("cont_b0_stop", obs0, 5'b0);

        // Stop during channel 2 DRIVE (cycle 15).
        tick(); tag = "stop";
        start = 1; oneshot = 0; div = 3;
        push(0, 0, 0, 0);
        push_chan(0, 3);
        push_chan(1, 3);
        repeat (2) push(2, 0, 1, 0);
        push(2, 1, 1, 0);
        repeat (2) push(0, 0, 0, 0);
        tick(); start = 0;
        repeat (14) tick();
        stop = 1;
        tick(); stop = 0;
        drain();

        // start and stop together in IDLE: stop wins.
        tick(); tag = "start_stop";
        start = 1; stop = 1;
        repeat (3) push(0, 0, 0, 0);
        tick(); start = 0; stop = 0;
        drain();

        // div 3->7 mid-window; start pulse while busy ignored.
        tick(); tag = "div_change";
        start = 1; oneshot = 1; div = 3;
        push(0, 0, 0, 0);
        push_chan(0, 3);
        for (int ch = 1; ch < 4; ch++) push_chan(ch, 7);
        push(0, 0, 0, 1);
        push(0, 0, 0, 0);
        tick(); start = 0;
        repeat (3) tick();
        div = 7;
        repeat (6) tick();
        start = 1;
        tick(); start = 0;
        drain();

        // Async reset in the middle of a DRIVE window.
        tick(); tag = "rst_mid";
        start = 1; oneshot = 0; div = 3;
        tick(); start = 0;
        repeat (3) tick();
        chk("rst_mid_drive", obs, 5'b00110);
        #2 rst = 1'b1;
        #1 chk("rst_mid_async", obs, 5'b0);
        tick(); rst = 1'b0;
        tick();
        chk("rst_mid_idle", obs, 5'b0);
        tick();
        chk("rst_mid_stay", obs, 5'b0);

`ifdef SCAN_MASK_EN
        // Only channels 1 and 3 enabled.
        tick(); tag = "mask_1010";
        mask = 4'b1010; start = 1; oneshot = 1; div = 1;
        push(0, 0, 0, 0);
        push_chan(1, 1);
        push_chan(3, 1);
        push(0, 0, 0, 1);
        push(0, 0, 0, 0);
        tick(); start = 0;
        drain();

        // Empty mask at start: done pulse only.
        tick(); tag = "mask_0000";
        mask = 4'b0000; start = 1; oneshot = 1;
        push(0, 0, 0, 0);
        push(0, 0, 0, 1);
        push(0, 0, 0, 0);
        tick(); start = 0;
        drain();
        mask = 4'hF;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
